// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic inter-stage pipeline register with a valid/ready
// handshake and a 2-entry skid buffer (main register + skid register).
// in_ready is decoded purely from the state register, so upstream never sees
// a combinational path from out_ready. Empty slots present a zero-control
// bubble downstream. A flush squashes everything held in the stage.
//
// Optional build macro: PIPE_STAGE_PERF_EN adds saturating stall/bubble
// counters (stall_cnt, bubble_cnt). Without it those ports do not exist.
`timescale 1ns/1ps

module pipe_stage_skid #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned CTRL_W        = 6,
  parameter int unsigned ZERO_ON_EMPTY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_STAGE_PERF_EN
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt,
`endif
  output logic [1:0]        occupancy
);

  // EMPTY: nothing held; BUSY: main register valid; FULL: main + skid valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [DATA_W-1:0]   w_main_data_nxt;
  logic [CTRL_W-1:0]   w_main_ctrl_nxt;
  logic [DATA_W-1:0]   w_skid_data_nxt;
  logic [CTRL_W-1:0]   w_skid_ctrl_nxt;

  logic                w_in_ready;
  logic                w_out_valid;
  logic [1:0]          w_occupancy;
  logic                w_in_fire;
  logic                w_out_fire;

  // Handshake signals decoded from the state register only.
  always_comb begin
    w_in_ready  = 1'b1;
    w_out_valid = 1'b0;
    w_occupancy = 2'd0;
    case (r_state)
      ST_EMPTY: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
        w_occupancy = 2'd0;
      end
      ST_BUSY: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b1;
        w_occupancy = 2'd1;
      end
      ST_FULL: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b1;
        w_occupancy = 2'd2;
      end
      default: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
        w_occupancy = 2'd0;
      end
    endcase
  end

  assign w_in_fire  = in_valid & w_in_ready;
  assign w_out_fire = w_out_valid & out_ready;

  // Next-state and payload steering; flush overrides the handshake.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_data_nxt = r_main_data;
    w_main_ctrl_nxt = r_main_ctrl;
    w_skid_data_nxt = r_skid_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    if (flush) begin
      // Any same-cycle in_fire is dropped; a same-cycle out_fire was
      // already seen downstream and needs no action here.
      w_state_nxt     = ST_EMPTY;
      w_main_data_nxt = '0;
      w_main_ctrl_nxt = '0;
      w_skid_data_nxt = '0;
      w_skid_ctrl_nxt = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt     = ST_BUSY;
            w_main_data_nxt = in_data;
            w_main_ctrl_nxt = in_ctrl;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_BUSY: begin
          case ({w_in_fire, w_out_fire})
            2'b10: begin
              // Downstream stalled: the new entry parks in the skid slot,
              // so it stays younger than the one in main.
              w_state_nxt     = ST_FULL;
              w_skid_data_nxt = in_data;
              w_skid_ctrl_nxt = in_ctrl;
            end
            2'b01: begin
              w_state_nxt = ST_EMPTY;
              if (ZERO_ON_EMPTY != 0) begin
                w_main_data_nxt = '0;
                w_main_ctrl_nxt = '0;
              end else begin
                w_main_data_nxt = r_main_data;
                w_main_ctrl_nxt = r_main_ctrl;
              end
            end
            2'b11: begin
              w_state_nxt     = ST_BUSY;
              w_main_data_nxt = in_data;
              w_main_ctrl_nxt = in_ctrl;
            end
            default: begin
              w_state_nxt = ST_BUSY;
            end
          endcase
        end
        ST_FULL: begin
          // in_ready is low here, so in_valid is ignored.
          if (w_out_fire) begin
            w_state_nxt     = ST_BUSY;
            w_main_data_nxt = r_skid_data;
            w_main_ctrl_nxt = r_skid_ctrl;
            w_skid_data_nxt = '0;
            w_skid_ctrl_nxt = '0;
          end else begin
            w_state_nxt = ST_FULL;
          end
        end
        default: begin
          w_state_nxt     = ST_EMPTY;
          w_main_data_nxt = '0;
          w_main_ctrl_nxt = '0;
          w_skid_data_nxt = '0;
          w_skid_ctrl_nxt = '0;
        end
      endcase
    end
  end

  // State and payload registers; reset has top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_main_data <= w_main_data_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign occupancy = w_occupancy;
  assign out_data  = r_main_data;
  // Control is gated so a stale main register never leaks a live opcode.
  assign out_ctrl  = r_main_ctrl & {CTRL_W{w_out_valid}};

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_bubble_cnt;

  // Saturating stall/bubble counters; cleared only by reset, not by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= 16'd0;
      r_bubble_cnt <= 16'd0;
    end else begin
      if (w_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (!w_out_valid && out_ready && (r_bubble_cnt != 16'hFFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end else begin
        r_bubble_cnt <= r_bubble_cnt;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (default parameters).
// Inputs change 1ns after each rising edge; outputs are sampled there too.
`timescale 1ns/1ps

module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [5:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_ctrl;
  logic [1:0]  occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] bubble_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reset image: {out_valid, in_ready, occupancy, out_ctrl, out_data}.
  localparam logic [41:0] RST_IMG = {1'b0, 1'b1, 2'd0, 6'd0, 32'd0};

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(6), .ZERO_ON_EMPTY(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
`endif
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0;
    in_ctrl = 6'd0; out_ready = 1'b0;
    step(); step();
    n_checks++;
    if ({out_valid, in_ready, occupancy, out_ctrl, out_data} !== RST_IMG) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h",
               {out_valid, in_ready, occupancy, out_ctrl, out_data}, RST_IMG);
    end
    rst = 1'b0;
    step(); step();
    n_checks++;
    if ({out_valid, in_ready, occupancy, out_ctrl, out_data} !== RST_IMG) begin
      n_fail++;
      $display("FAIL idle_values: got %h expected %h",
               {out_valid, in_ready, occupancy, out_ctrl, out_data}, RST_IMG);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h1000 + 32'(i);
      in_ctrl  = 6'(i);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready);
      end
      step();
      n_checks++;
      if ({out_valid, occupancy, out_ctrl, out_data} !==
          {1'b1, 2'd1, 6'(i), 32'h1000 + 32'(i)}) begin
        n_fail++;
        $display("FAIL stream_out[%0d]: got v=%b occ=%0d ctrl=%0d data=%h expected v=1 occ=1 ctrl=%0d data=%h",
                 i, out_valid, occupancy, out_ctrl, out_data, i, 32'h1000 + 32'(i));
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if ({out_valid, in_ready, occupancy, out_ctrl, out_data} !== RST_IMG) begin
      n_fail++;
      $display("FAIL stream_drain: got %h expected %h",
               {out_valid, in_ready, occupancy, out_ctrl, out_data}, RST_IMG);
    end
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hAAAA0001; in_ctrl = 6'd1;
    step();
    n_checks++;
    if ({occupancy, out_data} !== {2'd1, 32'hAAAA0001}) begin
      n_fail++;
      $display("FAIL skid_push_a: got occ=%0d data=%h expected occ=1 data=aaaa0001",
               occupancy, out_data);
    end
    in_data = 32'hBBBB0002; in_ctrl = 6'd2;
    step();
    n_checks++;
    if ({occupancy, in_ready, out_valid, out_data} !== {2'd2, 1'b0, 1'b1, 32'hAAAA0001}) begin
      n_fail++;
      $display("FAIL skid_full: got occ=%0d rdy=%b v=%b data=%h expected occ=2 rdy=0 v=1 data=aaaa0001",
               occupancy, in_ready, out_valid, out_data);
    end
    // C offered while FULL and still stalled: everything must hold.
    in_data = 32'hCCCC0003; in_ctrl = 6'd3;
    step();
    n_checks++;
    if ({occupancy, out_ctrl, out_data} !== {2'd2, 6'd1, 32'hAAAA0001}) begin
      n_fail++;
      $display("FAIL skid_hold: got occ=%0d ctrl=%0d data=%h expected occ=2 ctrl=1 data=aaaa0001",
               occupancy, out_ctrl, out_data);
    end
    out_ready = 1'b1;
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, 32'hAAAA0001}) begin
      n_fail++;
      $display("FAIL skid_deliver_a: got v=%b data=%h expected v=1 data=aaaa0001",
               out_valid, out_data);
    end
    step();
    n_checks++;
    if ({out_valid, occupancy, out_ctrl, out_data} !== {1'b1, 2'd1, 6'd2, 32'hBBBB0002}) begin
      n_fail++;
      $display("FAIL skid_deliver_b: got v=%b occ=%0d ctrl=%0d data=%h expected v=1 occ=1 ctrl=2 data=bbbb0002",
               out_valid, occupancy, out_ctrl, out_data);
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if ({out_valid, occupancy, out_data} !== {1'b0, 2'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL skid_c_not_taken: got v=%b occ=%0d data=%h expected v=0 occ=0 data=0",
               out_valid, occupancy, out_data);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_0011; in_ctrl = 6'd3;
    step();
    in_data = 32'h0000_0022; in_ctrl = 6'd4;
    step();
    n_checks++;
    if (occupancy !== 2'd2) begin
      n_fail++;
      $display("FAIL flush_prefill: got occ=%0d expected 2", occupancy);
    end
    flush = 1'b1; in_data = 32'h0000_DEAD; in_ctrl = 6'd5;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, occupancy, out_ctrl, out_data} !== RST_IMG) begin
      n_fail++;
      $display("FAIL flush_empty: got %h expected %h",
               {out_valid, in_ready, occupancy, out_ctrl, out_data}, RST_IMG);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if ({out_valid, out_data} !== {1'b0, 32'd0}) begin
        n_fail++;
        $display("FAIL flush_no_emit[%0d]: got v=%b data=%h expected v=0 data=0",
                 k, out_valid, out_data);
      end
    end
  endtask

  task automatic test_rst_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_5555; in_ctrl = 6'd7;
    step();
    n_checks++;
    if (occupancy !== 2'd1) begin
      n_fail++;
      $display("FAIL rstflush_busy: got occ=%0d expected 1", occupancy);
    end
    rst = 1'b1; flush = 1'b1; in_data = 32'h0000_6666;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, occupancy, out_ctrl, out_data} !== RST_IMG) begin
      n_fail++;
      $display("FAIL rstflush_values: got %h expected %h",
               {out_valid, in_ready, occupancy, out_ctrl, out_data}, RST_IMG);
    end
    in_valid = 1'b1; in_data = 32'h0000_7777; in_ctrl = 6'd8;
    step();
    in_data = 32'h0000_8888; in_ctrl = 6'd9;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (occupancy !== 2'd2) begin
      n_fail++;
      $display("FAIL rstfull_prefill: got occ=%0d expected 2", occupancy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, occupancy, out_ctrl, out_data} !== RST_IMG) begin
      n_fail++;
      $display("FAIL rstfull_values: got %h expected %h",
               {out_valid, in_ready, occupancy, out_ctrl, out_data}, RST_IMG);
    end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
    n_checks++;
    if ({stall_cnt, bubble_cnt} !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_reset: got stall=%0d bubble=%0d expected 0 0", stall_cnt, bubble_cnt);
    end
    in_valid = 1'b1; in_data = 32'h0000_0042; in_ctrl = 6'd1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    out_ready = 1'b1;
    step();
    repeat (3) step();
    out_ready = 1'b0;
    n_checks++;
    if ({stall_cnt, bubble_cnt} !== {16'd5, 16'd3}) begin
      n_fail++;
      $display("FAIL perf_counts: got stall=%0d bubble=%0d expected 5 3", stall_cnt, bubble_cnt);
    end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (70000) step();
    n_checks++;
    if (stall_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL perf_saturate: got stall=%h expected ffff", stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_skid();
    test_flush();
    test_rst_flush();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
